// File: rtl/mem_pkg.sv
// Shared definitions for the M-stage data memory access controller:
// FSM state encoding, MemSizeM encodings and the default bus-wait limit.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // The bus only ever sees word addresses; lane selection is via byte enables.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_be_gen.sv
// Byte-enable / store-data lane generator (purely combinational).
// Produces the bus byte enables, the lane-replicated write data and the
// misalignment flag from the access size, the low address bits and rs2.
module mem_be_gen
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  // Each byte lane takes the low byte (byte), the matching byte of the low
  // half (half) or its own byte (word), so the slave never needs to shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata[gi*8 +: 8] = (size == SIZE_BYTE) ? store_data[7:0] :
                              (size == SIZE_HALF) ? store_data[(gi%2)*8 +: 8] :
                                                    store_data[gi*8 +: 8];
  end

  // Byte enables and misalignment detection per access size
  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      SIZE_WORD: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      SIZE_RSVD: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data memory access controller.
// Launches one registered bus transaction per load/store, stalls the
// pipeline until it completes, and returns the raw loaded word.
// Optional feature: define MEM_TIMEOUT_EN to abort bus waits after
// TIMEOUT_CYCLES cycles in REQ/RESP with a one-cycle BusErrM pulse
// (TIMEOUT_CYCLES must be at least 1).
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemValidM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic [31:0] AluOutM,
  input  logic [31:0] StoreDataM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] RamDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  state_t      state_reg, state_next;
  logic        bus_req_reg, bus_req_next;
  logic        bus_we_reg, bus_we_next;
  logic [31:0] bus_addr_reg, bus_addr_next;
  logic [3:0]  bus_be_reg, bus_be_next;
  logic [31:0] bus_wdata_reg, bus_wdata_next;
  logic [31:0] ram_data_reg, ram_data_next;
  logic        misalign_reg, misalign_next;
  logic        bus_err_reg, bus_err_next;
  logic        stall;
  logic        timeout_hit;

  logic [3:0]  gen_be;
  logic [31:0] gen_wdata;
  logic        gen_misalign;

  mem_be_gen u_be_gen (
    .size      (MemSizeM),
    .addr_lo   (AluOutM[1:0]),
    .store_data(StoreDataM),
    .be        (gen_be),
    .wdata     (gen_wdata),
    .misalign  (gen_misalign)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Last allowed wait cycle: the abort takes effect at the end of it
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  // Wait counter: zero while idle (so zero on REQ entry), counts in REQ/RESP
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == IDLE) begin
      cnt_next = '0;
    end else if (state_reg == REQ || state_reg == RESP) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-register logic; StallM decoded from the current state
  always_comb begin
    state_next     = state_reg;
    bus_req_next   = bus_req_reg;
    bus_we_next    = bus_we_reg;
    bus_addr_next  = bus_addr_reg;
    bus_be_next    = bus_be_reg;
    bus_wdata_next = bus_wdata_reg;
    ram_data_next  = ram_data_reg;
    misalign_next  = 1'b0;
    bus_err_next   = 1'b0;
    stall          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MemValidM) begin
          stall = 1'b1;
          if (gen_misalign) begin
            // No bus cycle at all; report and let the pipeline move on
            misalign_next = 1'b1;
            ram_data_next = '0;
            state_next    = DONE;
          end else begin
            bus_req_next   = 1'b1;
            bus_we_next    = MemWriteM;
            bus_addr_next  = word_addr(AluOutM);
            bus_be_next    = gen_be;
            bus_wdata_next = gen_wdata;
            state_next     = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // Read data arriving with the grant is deliberately not looked at
        if (bus_gnt) begin
          bus_req_next = 1'b0;
          state_next   = bus_we_reg ? DONE : RESP;
        end else if (timeout_hit) begin
          bus_req_next  = 1'b0;
          bus_err_next  = 1'b1;
          ram_data_next = '0;
          state_next    = DONE;
        end
      end
      RESP: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          ram_data_next = bus_rdata;
          state_next    = DONE;
        end else if (timeout_hit) begin
          bus_err_next  = 1'b1;
          ram_data_next = '0;
          state_next    = DONE;
        end
      end
      DONE: begin
        // One unstalled cycle so the pipeline advances past this access
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_be_reg    <= '0;
      bus_wdata_reg <= '0;
      ram_data_reg  <= '0;
      misalign_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_req_reg   <= bus_req_next;
      bus_we_reg    <= bus_we_next;
      bus_addr_reg  <= bus_addr_next;
      bus_be_reg    <= bus_be_next;
      bus_wdata_reg <= bus_wdata_next;
      ram_data_reg  <= ram_data_next;
      misalign_reg  <= misalign_next;
      bus_err_reg   <= bus_err_next;
    end
  end

  assign bus_req   = bus_req_reg;
  assign bus_we    = bus_we_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_be    = bus_be_reg;
  assign bus_wdata = bus_wdata_reg;
  assign RamDataM  = ram_data_reg;
  assign StallM    = stall;
  assign MisalignM = misalign_reg;
  assign BusErrM   = bus_err_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected bus beats
// and access completions; a negedge monitor pops and compares them.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemValidM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [1:0]  MemSizeM = 2'd0;
  logic [31:0] AluOutM = '0;
  logic [31:0] StoreDataM = '0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] RamDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemValidM(MemValidM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
    .AluOutM(AluOutM), .StoreDataM(StoreDataM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .RamDataM(RamDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM)
  );

  typedef struct {
    logic [31:0] ram;
    logic        mis;
    logic        err;
    int          stalls;
  } done_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    mis_pulses = 0;
  int    err_pulses = 0;
  int    stall_cnt = 0;
  int    txn_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: bus beats on grant, access completions when StallM falls
  always @(negedge clk) begin
    bus_t  b;
    done_t d;
    if (!rst_n) begin
      stall_cnt = 0;
    end else begin
      if (MisalignM) mis_pulses++;
      if (BusErrM) err_pulses++;
      if (bus_req && bus_gnt) begin
        if (bus_q.size() == 0) begin
          check("unexpected bus beat", 32'(bus_addr), 32'hFFFF_FFFF);
        end else begin
          b = bus_q.pop_front();
          check("bus_we", 32'(bus_we), 32'(b.we));
          check("bus_addr", bus_addr, b.addr);
          check("bus_be", 32'(bus_be), 32'(b.be));
          check("bus_wdata", bus_wdata, b.wdata);
        end
      end
      if (StallM) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (done_q.size() == 0) begin
          check("unexpected completion", 32'(stall_cnt), 32'd0);
        end else begin
          d = done_q.pop_front();
          txn_no++;
          $display("txn %0d: RamDataM=%08h MisalignM=%0b BusErrM=%0b stall_cycles=%0d",
                   txn_no, RamDataM, MisalignM, BusErrM, stall_cnt);
          check("RamDataM", RamDataM, d.ram);
          check("MisalignM", 32'(MisalignM), 32'(d.mis));
          check("BusErrM", 32'(BusErrM), 32'(d.err));
          check("stall_cycles", 32'(stall_cnt), 32'(d.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  // Issue one access and play the bus slave until the DONE cycle.
  // gnt_at/rv_at: REQ/RESP cycle (1-based) carrying gnt/rvalid; 0 = never.
  task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] sdata, input int gnt_at, input int rv_at,
                        input logic rv_with_gnt, input logic [31:0] rdata,
                        input logic aligned);
    int   req_n = 0;
    int   resp_n = 0;
    int   cyc = 0;
    logic granted = 1'b0;
    @(posedge clk); #1;
    MemValidM = 1'b1; MemWriteM = we; MemSizeM = sz; AluOutM = addr; StoreDataM = sdata;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (!StallM) break;
      cyc++;
      if (cyc > 64) begin
        check("access wait bound", 32'(cyc), 32'd64);
        break;
      end
      @(posedge clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hFFFF_FFFF;
      if (cyc == 1) check("request issued", 32'(bus_req), 32'(aligned));
      if (granted && !we) begin
        resp_n++;
        if (resp_n == rv_at) begin
          bus_rvalid = 1'b1; bus_rdata = rdata;
        end
      end else if (bus_req) begin
        req_n++;
        if (req_n == gnt_at) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
          if (rv_with_gnt) begin
            bus_rvalid = 1'b1; bus_rdata = 32'h5A5A_5A5A;
          end
        end
      end
    end
    // Rest of the DONE cycle: stray handshakes that must be ignored
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAAD_BAAD;
  endtask

  // Idle cycles with noisy bus inputs
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      MemValidM = 1'b0;
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAAD_0000 + 32'(i);
    end
  endtask

  initial begin
    int exp_err;
    exp_err = 0;
    // Reset state
    @(negedge clk); @(negedge clk);
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset bus_we", 32'(bus_we), 32'd0);
    check("reset bus_addr", bus_addr, 32'd0);
    check("reset bus_be", 32'(bus_be), 32'd0);
    check("reset bus_wdata", bus_wdata, 32'd0);
    check("reset RamDataM", RamDataM, 32'd0);
    check("reset StallM", 32'(StallM), 32'd0);
    check("reset MisalignM", 32'(MisalignM), 32'd0);
    check("reset BusErrM", 32'(BusErrM), 32'd0);
    rst_n = 1'b1;

    // Load word 0x100, grant in 2nd REQ cycle, rvalid next: 4 stall cycles
    bus_q.push_back('{1'b0, 32'h0000_0100, 4'hF, 32'h1122_3344});
    done_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0, 4});
    access(1'b0, SIZE_WORD, 32'h100, 32'h1122_3344, 2, 1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    idle(2);

    // Store byte 0xA5 at 0x103: DONE right after grant, RamDataM untouched
    bus_q.push_back('{1'b1, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5});
    done_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0, 2});
    access(1'b1, SIZE_BYTE, 32'h103, 32'h0000_00A5, 1, 0, 1'b0, 32'h0, 1'b1);
    idle(1);

    // Load half at 0x101: misaligned, no bus cycle
    done_q.push_back('{32'h0, 1'b1, 1'b0, 1});
    access(1'b0, SIZE_HALF, 32'h101, 32'h0, 1, 1, 1'b0, 32'h1234_5678, 1'b0);
    idle(1);

    // Load byte 0x42: rvalid alongside grant is junk, real data 2nd RESP cycle
    bus_q.push_back('{1'b0, 32'h0000_0040, 4'b0100, 32'hC3C3_C3C3});
    done_q.push_back('{32'hCAFE_F00D, 1'b0, 1'b0, 4});
    access(1'b0, SIZE_BYTE, 32'h42, 32'h0000_00C3, 1, 2, 1'b1, 32'hCAFE_F00D, 1'b1);
    idle(1);

    // Store half 0x5678 at 0x206, grant in 3rd REQ cycle
    bus_q.push_back('{1'b1, 32'h0000_0204, 4'b1100, 32'h5678_5678});
    done_q.push_back('{32'hCAFE_F00D, 1'b0, 1'b0, 4});
    access(1'b1, SIZE_HALF, 32'h206, 32'h1234_5678, 3, 0, 1'b0, 32'h0, 1'b1);
    idle(3);

    // Back-to-back with MemValidM held: store word, load half (min latency),
    // reserved size, misaligned word
    bus_q.push_back('{1'b1, 32'h0000_0300, 4'hF, 32'h89AB_CDEF});
    bus_q.push_back('{1'b0, 32'h0000_0000, 4'b1100, 32'hBEEF_BEEF});
    done_q.push_back('{32'hCAFE_F00D, 1'b0, 1'b0, 2});
    done_q.push_back('{32'h0BAD_F00D, 1'b0, 1'b0, 3});
    done_q.push_back('{32'h0, 1'b1, 1'b0, 1});
    done_q.push_back('{32'h0, 1'b1, 1'b0, 1});
    access(1'b1, SIZE_WORD, 32'h300, 32'h89AB_CDEF, 1, 0, 1'b0, 32'h0, 1'b1);
    access(1'b0, SIZE_HALF, 32'h002, 32'h0000_BEEF, 1, 1, 1'b0, 32'h0BAD_F00D, 1'b1);
    access(1'b0, SIZE_RSVD, 32'h000, 32'h0, 1, 1, 1'b0, 32'h0, 1'b0);
    access(1'b0, SIZE_WORD, 32'h002, 32'h0, 1, 1, 1'b0, 32'h0, 1'b0);
    idle(1);

    // Load word 0x104 so RamDataM is non-zero before the reset test
    bus_q.push_back('{1'b0, 32'h0000_0104, 4'hF, 32'h0});
    done_q.push_back('{32'h600D_CAFE, 1'b0, 1'b0, 3});
    access(1'b0, SIZE_WORD, 32'h104, 32'h0, 1, 1, 1'b0, 32'h600D_CAFE, 1'b1);
    idle(1);

    // Reset while in RESP: transaction abandoned, later rvalid ignored
    bus_q.push_back('{1'b0, 32'h0000_0080, 4'hF, 32'h0});
    @(posedge clk); #1;
    MemValidM = 1'b1; MemWriteM = 1'b0; MemSizeM = SIZE_WORD; AluOutM = 32'h80; StoreDataM = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    check("stall in RESP", 32'(StallM), 32'd1);
    rst_n = 1'b0; MemValidM = 1'b0;
    #1;
    check("async reset bus_req", 32'(bus_req), 32'd0);
    check("async reset StallM", 32'(StallM), 32'd0);
    check("async reset RamDataM", RamDataM, 32'd0);
    check("async reset bus_addr", bus_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_0080;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("stray rvalid RamDataM", RamDataM, 32'd0);
    check("stray rvalid StallM", 32'(StallM), 32'd0);
    check("stray rvalid bus_req", 32'(bus_req), 32'd0);

    // First access after reset: store byte 0x3C at 0x001
    bus_q.push_back('{1'b1, 32'h0000_0000, 4'b0010, 32'h3C3C_3C3C});
    done_q.push_back('{32'h0, 1'b0, 1'b0, 2});
    access(1'b1, SIZE_BYTE, 32'h001, 32'h0000_003C, 1, 0, 1'b0, 32'h0, 1'b1);
    idle(1);

    // Load word 0x500
    bus_q.push_back('{1'b0, 32'h0000_0500, 4'hF, 32'h0});
    done_q.push_back('{32'h7777_8888, 1'b0, 1'b0, 3});
    access(1'b0, SIZE_WORD, 32'h500, 32'h0, 1, 1, 1'b0, 32'h7777_8888, 1'b1);
    idle(1);

`ifdef MEM_TIMEOUT_EN
    // No grant ever: abort after 4 REQ cycles with BusErrM, RamDataM cleared
    exp_err = 1;
    done_q.push_back('{32'h0, 1'b0, 1'b1, 5});
    access(1'b0, SIZE_WORD, 32'h400, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1);
    idle(1);
`endif

    idle(3);
    check("completions left", 32'(done_q.size()), 32'd0);
    check("bus beats left", 32'(bus_q.size()), 32'd0);
    check("MisalignM pulses", 32'(mis_pulses), 32'd3);
    check("BusErrM pulses", 32'(err_pulses), 32'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus-wait cycles before abort; used only with MEM_TIMEOUT_EN.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 MemValidM  in  1  M-stage instruction is a load or store.
REQ-005 MemWriteM  in  1  1=store, 0=load.
REQ-006 MemSizeM  in  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-007 AluOutM  in  32  byte address.
REQ-008 StoreDataM  in  32  rs2 store data, LSB-aligned.
REQ-009 bus_req  out  1  registered request to data bus.
REQ-010 bus_we  out  1  registered write strobe.
REQ-011 bus_addr  out  32  registered, word-aligned {AluOutM[31:2],2'b00}.
REQ-012 bus_be  out  4  registered byte enables.
REQ-013 bus_wdata  out  32  registered, lane-replicated store data.
REQ-014 bus_gnt  in  1  bus accepted request.
REQ-015 bus_rvalid  in  1  read data valid.
REQ-016 bus_rdata  in  32  read word.
REQ-017 RamDataM  out  32  raw loaded word to WB pipeline register; byte selection is done downstream.
REQ-018 StallM  out  1  freeze IF..M stages.
REQ-019 MisalignM  out  1  one-cycle misaligned-access pulse.
REQ-020 BusErrM  out  1  one-cycle timeout pulse.

Function
REQ-021 FSM states SHALL be IDLE, REQ, RESP, DONE.
REQ-022 IDLE + MemValidM, aligned: register bus outputs, bus_req=1, go REQ.
REQ-023 REQ: hold all bus outputs stable until bus_gnt; on gnt drop bus_req, go DONE for stores, RESP for loads.
REQ-024 RESP: on bus_rvalid capture bus_rdata into RamDataM, go DONE.
REQ-025 DONE: StallM=0 for exactly one cycle, so the pipeline advances; then IDLE.
REQ-026 StallM = (IDLE & MemValidM) | REQ | RESP.
REQ-027 Minimum latency: a load with gnt in the first REQ cycle and rvalid the next cycle stalls 3 cycles.
REQ-028 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-029 bus_wdata: byte replicated x4; half replicated x2; word unchanged.
REQ-030 Misaligned access (half with addr[0]=1, word with addr[1:0]!=0, or size 3): no bus access; pulse MisalignM; RamDataM=0; go DONE directly.
REQ-031 RamDataM SHALL hold its value until the next load completes; stores leave it unchanged.
REQ-032 bus_gnt and bus_rvalid SHALL be ignored in IDLE and DONE.
REQ-033 An rvalid in the same cycle as gnt SHALL NOT be accepted; data is taken only in RESP.

Reset
REQ-034 On rst_n=0, immediately: state=IDLE; bus_req, bus_we, bus_be, MisalignM, BusErrM=0; bus_addr, bus_wdata, RamDataM=0; timeout counter=0.
REQ-035 Reset mid-transaction SHALL abandon the transaction without a response; the first post-reset cycle is IDLE.

Configuration
REQ-036 With MEM_TIMEOUT_EN defined, a counter runs in REQ/RESP and clears on entry to REQ.
REQ-037 When the counter reaches TIMEOUT_CYCLES, the block SHALL drop bus_req, pulse BusErrM, set RamDataM=0 and go DONE.
REQ-038 Without MEM_TIMEOUT_EN: no counter, BusErrM tied 0, and the FSM waits indefinitely.

Structure
REQ-039 Shared package mem_pkg SHALL hold the state enum, the MemSize encodings and the default TIMEOUT_CYCLES.
REQ-040 Sub-module mem_be_gen SHALL be combinational; it produces bus_be, bus_wdata and the misalign flag from size, addr[1:0] and store data.

Verification
REQ-041 Load word at 0x100, gnt after 2 cycles, rvalid next -> bus_be=4'hF, RamDataM=bus_rdata, StallM high 4 cycles.
REQ-042 Store byte 0xA5 at 0x103 -> bus_be=4'b1000, bus_wdata=0xA5A5A5A5, DONE immediately after gnt.
REQ-043 Load half at 0x101 -> MisalignM one pulse, bus_req never asserted, RamDataM=0.
REQ-044 rst_n low while in RESP -> bus_req=0 and state IDLE at once; a later rvalid is ignored.
REQ-045 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, gnt never asserted -> BusErrM pulse after 4 REQ cycles, then StallM=0.
REQ-046 Back-to-back load/store with MemValidM held high -> second request issued in the cycle after DONE; each access completes independently.
